// File: rtl/md5_compress.sv
// Iterative MD5 compression core, STEPS_PER_CYCLE unrolled steps per clock.
// Optional MD5_COMPRESS_CHAIN_EN adds chain_from_digest to reuse digest_out as the chaining value.
module md5_compress #(
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] block_in,
    input  logic [127:0] chain_in,
`ifdef MD5_COMPRESS_CHAIN_EN
    input  logic         chain_from_digest,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] digest_out,
    output logic         busy
);

    generate
        if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2 ||
              STEPS_PER_CYCLE == 4 || STEPS_PER_CYCLE == 8)) begin : g_bad_steps
            $error("md5_compress: STEPS_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    localparam logic [5:0] LAST = 6'(64 - STEPS_PER_CYCLE);

    localparam logic [31:0] K_TAB [0:63] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // Indexed by {round, step%4}
    localparam logic [4:0] SH [0:15] = '{
        5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21
    };

    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] s);
        logic [63:0] t;
        t = {x, x} << s;
        return t[63:32];
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [5:0]     step;
    logic [31:0]    a, b, c, d;
    logic [31:0]    na, nb, nc, nd;
    logic [127:0]   chain_q, chain_sel;
    logic [511:0]   blk;
    logic           accept;
    logic [5:0]     idx;
    logic [3:0]     g;
    logic [31:0]    f, sum, tmp;

`ifdef MD5_COMPRESS_CHAIN_EN
    assign chain_sel = chain_from_digest ? digest_out : chain_in;
`else
    assign chain_sel = chain_in;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                accept   = in_valid;
                if (in_valid) state_nxt = RUN;
            end
            RUN:  if (step == LAST) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Groups never straddle a round, so step[5:4] selects the round for the whole cycle.
    always_comb begin
        na  = a;
        nb  = b;
        nc  = c;
        nd  = d;
        idx = '0;
        g   = '0;
        f   = '0;
        sum = '0;
        tmp = '0;
        for (int j = 0; j < STEPS_PER_CYCLE; j++) begin
            idx = step + 6'(j);
            case (step[5:4])
                2'd0: begin f = (nb & nc) | (~nb & nd); g = idx[3:0];                end
                2'd1: begin f = (nd & nb) | (~nd & nc); g = idx[3:0] * 4'd5 + 4'd1; end
                2'd2: begin f = nb ^ nc ^ nd;           g = idx[3:0] * 4'd3 + 4'd5; end
                default: begin f = nc ^ (nb | ~nd);     g = idx[3:0] * 4'd7;        end
            endcase
            sum = na + f + K_TAB[idx] + blk[{g, 5'b0} +: 32];
            tmp = nb + rotl32(sum, SH[{step[5:4], idx[1:0]}]);
            na  = nd;
            nd  = nc;
            nc  = nb;
            nb  = tmp;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a          <= '0;
            b          <= '0;
            c          <= '0;
            d          <= '0;
            step       <= '0;
            chain_q    <= '0;
            blk        <= '0;
            digest_out <= '0;
        end else if (accept) begin
            {d, c, b, a} <= chain_sel;
            chain_q      <= chain_sel;
            blk          <= block_in;
            step         <= '0;
        end else if (state == RUN) begin
            a    <= na;
            b    <= nb;
            c    <= nc;
            d    <= nd;
            step <= step + 6'(STEPS_PER_CYCLE);
            if (step == LAST)
                digest_out <= {nd + chain_q[127:96], nc + chain_q[95:64],
                               nb + chain_q[63:32],  na + chain_q[31:0]};
        end
    end

endmodule

// File: tb/tb_md5_compress.sv
// Directed bench for md5_compress: known digests, latency for all unroll factors, handshakes, reset.
module tb_md5_compress;

    localparam logic [127:0] IV      = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
    localparam logic [127:0] D_EMPTY = 128'h7e42f8ec_980980e9_04b2008f_d98c1dd4;
    localparam logic [127:0] D_ABC   = 128'h727fe128_7d3f96d6_b04fd23c_98500190;
    localparam logic [511:0] B_EMPTY = 512'h80;
    localparam logic [511:0] B_ABC   = (512'h18 << 448) | 512'h80636261;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         aux_valid = 1'b0;
    logic [511:0] block_in = '0;
    logic [127:0] chain_in = '0;
    logic         in_ready, out_valid, busy;
    logic [127:0] digest_out;
    logic [2:0]   aux_in_ready, aux_out_valid, aux_busy;
    logic [127:0] aux_digest [3];
`ifdef MD5_COMPRESS_CHAIN_EN
    logic         chain_from_digest = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    md5_compress #(.STEPS_PER_CYCLE(1)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .block_in(block_in),
        .chain_in(chain_in),
`ifdef MD5_COMPRESS_CHAIN_EN
        .chain_from_digest(chain_from_digest),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .digest_out(digest_out),
        .busy(busy)
    );

    // Wider unroll factors, used for the latency/digest check of the first block
    for (genvar gi = 0; gi < 3; gi++) begin : g_aux
        md5_compress #(.STEPS_PER_CYCLE(2 << gi)) u_aux (
            .clk(clk),
            .reset_n(reset_n),
            .in_valid(aux_valid),
            .in_ready(aux_in_ready[gi]),
            .block_in(block_in),
            .chain_in(chain_in),
`ifdef MD5_COMPRESS_CHAIN_EN
            .chain_from_digest(1'b0),
`endif
            .out_valid(aux_out_valid[gi]),
            .out_ready(1'b1),
            .digest_out(aux_digest[gi]),
            .busy(aux_busy[gi])
        );
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_block(input logic [511:0] blk, input logic [127:0] ch,
                             output logic [127:0] dig, output int lat);
        @(negedge clk);
        block_in = blk;
        chain_in = ch;
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("accept_busy", {127'b0, busy}, 128'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = -1;
        dig = '0;
        for (int c = 1; c <= 200 && lat < 0; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = c;
                dig = digest_out;
            end
        end
    endtask

    task automatic pop();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("pop_out_valid", {127'b0, out_valid}, 128'd0);
        chk("pop_in_ready", {127'b0, in_ready}, 128'd1);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

`ifdef MD5_COMPRESS_CHAIN_EN
    function automatic logic [127:0] md5_ref(input logic [511:0] blk, input logic [127:0] ch);
        int          sh [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
        logic [31:0] a, b, c, d, f, k, t, x;
        int          g, s;
        real         r;
        a = ch[31:0]; b = ch[63:32]; c = ch[95:64]; d = ch[127:96];
        for (int i = 0; i < 64; i++) begin
            if (i < 16)      begin f = (b & c) | (~b & d); g = i;              end
            else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
            else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
            else             begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
            r = $sin(real'(i + 1));
            if (r < 0.0) r = -r;
            k = 32'(longint'($floor(r * 4294967296.0)));
            s = sh[4 * (i / 16) + i % 4];
            x = a + f + k + blk[32 * g +: 32];
            t = b + ((x << s) | (x >> (32 - s)));
            a = d; d = c; c = b; b = t;
        end
        return {d + ch[127:96], c + ch[95:64], b + ch[63:32], a + ch[31:0]};
    endfunction
`endif

    initial begin
        logic [127:0] dig, d1;
        logic [127:0] dig_aux [3];
        int           lat, t1, t2;
        int           lat_aux [3];
        logic         ir1, ir2;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
        chk("rst_busy", {127'b0, busy}, 128'd0);
        chk("rst_digest", digest_out, 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_in_ready", {127'b0, in_ready}, 128'd1);
        chk("rst_aux_in_ready", {125'b0, aux_in_ready}, 128'd7);
        chk("rst_aux_busy", {125'b0, aux_busy}, 128'd0);

        // empty-string block on all unroll factors, latency 64/S
        @(negedge clk);
        block_in  = B_EMPTY;
        chain_in  = IV;
        in_valid  = 1'b1;
        aux_valid = 1'b1;
        @(posedge clk); #1;
        chk("accept_busy", {127'b0, busy}, 128'd1);
        chk("accept_in_ready", {127'b0, in_ready}, 128'd0);
        @(negedge clk);
        in_valid  = 1'b0;
        aux_valid = 1'b0;
        lat = -1;
        dig = '0;
        for (int k = 0; k < 3; k++) begin
            lat_aux[k] = -1;
            dig_aux[k] = '0;
        end
        for (int c = 1; c <= 70; c++) begin
            @(posedge clk); #1;
            if (out_valid && lat < 0) begin
                lat = c;
                dig = digest_out;
            end
            for (int k = 0; k < 3; k++)
                if (aux_out_valid[k] && lat_aux[k] < 0) begin
                    lat_aux[k] = c;
                    dig_aux[k] = aux_digest[k];
                end
        end
        chk("empty_lat_s1", 128'(lat), 128'd64);
        chk("empty_dig_s1", dig, D_EMPTY);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("empty_lat_s%0d", 2 << k), 128'(lat_aux[k]), 128'(32 >> k));
            chk($sformatf("empty_dig_s%0d", 2 << k), dig_aux[k], D_EMPTY);
        end

        // DONE held with out_ready low; a stray in_valid pulse must be ignored
        for (int h = 0; h < 10; h++) begin
            @(negedge clk);
            in_valid = (h == 4);
            block_in = (h == 4) ? B_ABC : B_EMPTY;
            @(posedge clk); #1;
            chk("hold_out_valid", {127'b0, out_valid}, 128'd1);
            chk("hold_digest", digest_out, D_EMPTY);
            chk("hold_in_ready", {127'b0, in_ready}, 128'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        pop();
        chk("pop_digest_kept", digest_out, D_EMPTY);
        chk("pop_busy", {127'b0, busy}, 128'd0);

        // "abc"
        run_block(B_ABC, IV, dig, lat);
        chk("abc_lat", 128'(lat), 128'd64);
        chk("abc_dig", dig, D_ABC);
        pop();

        // reset at step 30 of a run
        @(negedge clk);
        block_in = B_EMPTY;
        chain_in = IV;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", {127'b0, out_valid}, 128'd0);
        chk("midrst_busy", {127'b0, busy}, 128'd0);
        chk("midrst_digest", digest_out, 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("midrst_in_ready", {127'b0, in_ready}, 128'd1);
        run_block(B_EMPTY, IV, dig, lat);
        chk("after_rst_dig", dig, D_EMPTY);
        chk("after_rst_lat", 128'(lat), 128'd64);
        pop();

        // back-to-back with in_valid and out_ready held high
        @(negedge clk);
        block_in  = B_EMPTY;
        chain_in  = IV;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        t1 = -1;
        t2 = -1;
        ir1 = 1'b0;
        ir2 = 1'b1;
        for (int c = 1; c <= 300 && t2 < 0; c++) begin
            @(posedge clk); #1;
            if (t1 > 0 && c == t1 + 1) ir1 = in_ready;
            if (t1 > 0 && c == t1 + 2) ir2 = in_ready;
            if (out_valid) begin
                if (t1 < 0) begin
                    t1 = c;
                    chk("b2b_dig1", digest_out, D_EMPTY);
                end else begin
                    t2 = c;
                    chk("b2b_dig2", digest_out, D_EMPTY);
                end
            end
        end
        chk("b2b_first_lat", 128'(t1), 128'd65);
        chk("b2b_period", 128'(t2 - t1), 128'd66);
        chk("b2b_idle_ready", {127'b0, ir1}, 128'd1);
        chk("b2b_reaccept", {127'b0, ir2}, 128'd0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b_drain_valid", {127'b0, out_valid}, 128'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("b2b_drain_busy", {127'b0, busy}, 128'd0);
        @(negedge clk);
        out_ready = 1'b0;

`ifdef MD5_COMPRESS_CHAIN_EN
        // two-block chaining through digest_out; chain_in is garbage for the second block
        chain_from_digest = 1'b0;
        run_block(B_ABC, IV, d1, lat);
        chk("chain_blk1", d1, D_ABC);
        pop();
        chain_from_digest = 1'b1;
        run_block(B_ABC, 128'hdeadbeef_0badf00d_55aa55aa_12345678, dig, lat);
        chk("chain_blk2", dig, md5_ref(B_ABC, d1));
        pop();
        chain_from_digest = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
